// File: rtl/fib_checker_pkg.sv
// -----------------------------------------------------------------------------
// fib_checker_pkg
// Shared constants for the Fibonacci stream checker: the expected-value table,
// its length and largest value, and the checker state encoding.
// -----------------------------------------------------------------------------
package fib_checker_pkg;

  localparam int         FIB_LEN = 13;
  localparam logic [7:0] FIB_MAX = 8'd144;

  localparam logic [7:0] FIB_ROM [FIB_LEN] = '{
    8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
    8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144
  };

  localparam logic [3:0] IDX_LAST = 4'(FIB_LEN - 1);

  // Checker states (plain constants so legacy code can share the encoding).
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Sequence position arithmetic is modulo FIB_LEN.
  function automatic logic [3:0] next_index(input logic [3:0] idx);
    return (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/fib_rom.sv
// -----------------------------------------------------------------------------
// fib_rom
// Combinational lookup of the expected Fibonacci value for a sequence index.
// Ports:
//   i_index  [3:0]  sequence index (0..12 valid; 13..15 return 0)
//   o_value  [7:0]  expected sample value
// -----------------------------------------------------------------------------
module fib_rom
  import fib_checker_pkg::*;
(
  input  logic [3:0] i_index,
  output logic [7:0] o_value
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_value = '0;
    for (int i = 0; i < FIB_LEN; i++) begin
      if (i_index == 4'(i)) o_value = FIB_ROM[i];
    end
  end

endmodule

// File: rtl/fib_checker.sv
// -----------------------------------------------------------------------------
// fib_checker
// Tracks a producer's repeating Fibonacci stream (0,1,1,...,144). Hunts for a
// 0, acquires LOCK_MATCHES consecutive correct samples, then stays locked and
// reports mismatches (err_pulse / saturating err_count) and wraps (wrap_pulse).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid, in_data sample strobe and 8-bit sample
//   clr_count         synchronous clear of err_count (wins over an error)
//   locked            high while in LOCKED
//   seq_index [3:0]   index of the next expected value (0..12)
//   err_pulse         one-cycle pulse on a mismatch while locked
//   wrap_pulse        one-cycle pulse when 144 matches while locked
//   err_count [7:0]   saturating count of locked mismatches
// -----------------------------------------------------------------------------
module fib_checker
  import fib_checker_pkg::*;
#(
  parameter int LOCK_MATCHES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       clr_count,
  output logic       locked,
  output logic [3:0] seq_index,
  output logic       err_pulse,
  output logic       wrap_pulse,
  output logic [7:0] err_count
);

  logic [1:0] r_state;
  logic [3:0] r_index;
  logic [3:0] r_match_cnt;
  logic       r_locked;
  logic       r_err_pulse;
  logic       r_wrap_pulse;
  logic [7:0] r_err_count;

  logic [7:0] w_expected;
  logic       w_match;
  logic       w_err_event;
  logic [3:0] w_cnt_next;

  fib_rom u_fib_rom (
    .i_index (r_index),
    .o_value (w_expected)
  );

  assign w_match     = (in_data == w_expected);
  assign w_err_event = in_valid && (r_state == ST_LOCKED) && !w_match;
  assign w_cnt_next  = r_match_cnt + 4'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_index      <= 4'd0;
      r_match_cnt  <= 4'd0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= 8'd0;
    end else begin
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;

      if (in_valid) begin
        case (r_state)
          ST_HUNT: begin
            // Only a fresh 0 starts acquisition; index 0 expects exactly 0.
            if (w_match) begin
              r_state     <= ST_ACQ;
              r_index     <= 4'd1;
              r_match_cnt <= 4'd0;
            end else begin
              r_index <= 4'd0;
            end
          end

          ST_ACQ: begin
            if (w_match) begin
              r_index     <= next_index(r_index);
              r_match_cnt <= w_cnt_next;
              if (w_cnt_next == 4'(LOCK_MATCHES)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              // Silent fall-back: acquisition failures are not counted errors.
              r_state <= ST_HUNT;
              r_index <= 4'd0;
            end
          end

          ST_LOCKED: begin
            if (w_match) begin
              r_index      <= next_index(r_index);
              r_wrap_pulse <= (in_data == FIB_MAX);
            end else begin
              // The offending sample is discarded even if it is a 0.
              r_err_pulse <= 1'b1;
              r_state     <= ST_HUNT;
              r_index     <= 4'd0;
              r_locked    <= 1'b0;
            end
          end

          default: begin
            r_state  <= ST_HUNT;
            r_index  <= 4'd0;
            r_locked <= 1'b0;
          end
        endcase
      end

      // Clear has priority over a coincident error.
      if (clr_count) begin
        r_err_count <= 8'd0;
      end else if (w_err_event && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign locked     = r_locked;
  assign seq_index  = r_index;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_fib_checker.sv
// -----------------------------------------------------------------------------
// tb_fib_checker
// Scoreboard bench: each stimulus cycle pushes the expected outputs into a
// queue; a monitor pops and compares after every rising edge. Directed checks
// pin the hand-derived lock, wrap, error and reset timings.
// -----------------------------------------------------------------------------
module tb_fib_checker;

  typedef struct {
    logic       locked;
    logic [3:0] idx;
    logic       ep;
    logic       wp;
    logic [7:0] ec;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clr_count;
  logic       locked;
  logic [3:0] seq_index;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];

  int fib_tab [13] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};

  // Reference model state: 0 = HUNT, 1 = ACQ, 2 = LOCKED.
  int m_st, m_idx, m_cnt, m_err;

  fib_checker #(.LOCK_MATCHES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clr_count  (clr_count),
    .locked     (locked),
    .seq_index  (seq_index),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_idx = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // Drive one cycle at the falling edge and queue the expected post-edge state.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    clr_count = c;
    e.ep = 1'b0;
    e.wp = 1'b0;
    if (v) begin
      if (m_st == 0) begin
        if (d == 0) begin m_st = 1; m_idx = 1; m_cnt = 0; end
        else m_idx = 0;
      end else if (m_st == 1) begin
        if (int'(d) == fib_tab[m_idx]) begin
          m_idx = (m_idx + 1) % 13;
          m_cnt++;
          if (m_cnt == 2) m_st = 2;
        end else begin
          m_st = 0; m_idx = 0;
        end
      end else begin
        if (int'(d) == fib_tab[m_idx]) begin
          if (m_idx == 12) e.wp = 1'b1;
          m_idx = (m_idx + 1) % 13;
        end else begin
          e.ep = 1'b1; m_st = 0; m_idx = 0;
        end
      end
    end
    if (c) m_err = 0;
    else if (e.ep && m_err < 255) m_err++;
    e.locked = (m_st == 2);
    e.idx    = 4'(m_idx);
    e.ec     = 8'(m_err);
    sb.push_back(e);
  endtask

  // Wait for the edge that consumes the last driven sample.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
  endtask

  // Synchronous-style reset pulse; valid samples during reset must be ignored.
  task automatic do_reset();
    drain();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd0;
    model_reset();
    @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_seq_index", seq_index, 0);
    check("rst_err_count", err_count, 0);
    check("rst_pulses", {err_pulse, wrap_pulse}, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_ignored_sample", seq_index, 0);
  endtask

  task automatic lock_seq();
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd1, 1'b0);
  endtask

  // Monitor: compare every post-edge output set against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_locked", locked, e.locked);
        check("sb_seq_index", seq_index, e.idx);
        check("sb_err_pulse", err_pulse, e.ep);
        check("sb_wrap_pulse", wrap_pulse, e.wp);
        check("sb_err_count", err_count, e.ec);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    clr_count = 1'b0;
    model_reset();
    #12;
    check("reset_state_locked", locked, 0);
    check("reset_state_err_count", err_count, 0);
    do_reset();

    // Clean stream of 30 samples: lock after sample 3, wraps after 13 and 26.
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 8'(fib_tab[i % 13]), 1'b0);
      if (i == 1)  begin settle(); check("t1_not_locked_s2", locked, 0); end
      if (i == 2)  begin settle(); check("t1_locked_s3", locked, 1); end
      if (i == 12) begin settle(); check("t1_wrap_s13", wrap_pulse, 1); end
      if (i == 25) begin settle(); check("t1_wrap_s26", wrap_pulse, 1); end
    end
    settle();
    check("t1_err_count", err_count, 0);
    check("t1_seq_index", seq_index, 4);

    // Locked error: 3 then 7 where 5 is expected.
    step(1'b1, 8'd3, 1'b0);
    step(1'b1, 8'd7, 1'b0);
    settle();
    check("t2_err_pulse", err_pulse, 1);
    check("t2_err_count", err_count, 1);
    check("t2_locked", locked, 0);
    check("t2_seq_index", seq_index, 0);
    step(1'b0, 8'd0, 1'b0);
    settle();
    check("t2_err_pulse_one_cycle", err_pulse, 0);
    step(1'b1, 8'd0, 1'b0);
    settle();
    check("t2_acq_seq_index", seq_index, 1);
    check("t2_acq_not_locked", locked, 0);

    // Acquisition failure 0,1,4 is silent.
    do_reset();
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd4, 1'b0);
    settle();
    check("t3_err_pulse", err_pulse, 0);
    check("t3_err_count", err_count, 0);
    check("t3_seq_index", seq_index, 0);

    // A mismatching 0 while locked is not reused for resync.
    lock_seq();
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd0, 1'b0);
    settle();
    check("t3b_no_reuse_seq_index", seq_index, 0);
    check("t3b_err_count", err_count, 1);
    step(1'b1, 8'd0, 1'b0);
    settle();
    check("t3b_fresh_zero", seq_index, 1);

    // in_valid toggled every cycle: same timing in accepted-sample terms.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 8'(fib_tab[i % 13]), 1'b0);
      if (i == 1) begin settle(); check("t4_not_locked_s2", locked, 0); end
      if (i == 2) begin settle(); check("t4_locked_s3", locked, 1); end
      if (i == 12 || i == 25) begin settle(); check("t4_wrap", wrap_pulse, 1); end
      step(1'b0, 8'hAA, 1'b0);
      if (i == 12 || i == 25) begin settle(); check("t4_idle_no_wrap", wrap_pulse, 0); end
    end

    // 260 locked errors saturate at 255, then clear wins over an error.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      lock_seq();
      step(1'b1, 8'd200, 1'b0);
    end
    settle();
    check("t5_saturated", err_count, 255);
    check("t5_pulse_when_saturated", err_pulse, 1);
    lock_seq();
    step(1'b1, 8'd200, 1'b1);
    settle();
    check("t5_clear_wins", err_count, 0);
    check("t5_clear_err_pulse", err_pulse, 1);

    // Asynchronous reset while locked at seq_index 9.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(fib_tab[i]), 1'b0);
    drain();
    check("t6_pre_seq_index", seq_index, 9);
    check("t6_pre_locked", locked, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_locked", locked, 0);
    check("t6_async_seq_index", seq_index, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    settle();
    check("t6_relock_pending", locked, 0);
    step(1'b1, 8'd1, 1'b0);
    settle();
    check("t6_relocked", locked, 1);

    step(1'b0, 8'd0, 1'b0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
